// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM state type for the multi-cycle ALU.
package alu_pkg;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_MUL  = 4'b0010;
   localparam logic [3:0] OP_DIV  = 4'b0011;
   localparam logic [3:0] OP_SHL  = 4'b0100;
   localparam logic [3:0] OP_SHR  = 4'b0101;
   localparam logic [3:0] OP_GT   = 4'b0110;
   localparam logic [3:0] OP_LT   = 4'b0111;
   localparam logic [3:0] OP_EQ   = 4'b1000;
   localparam logic [3:0] OP_AND  = 4'b1001;
   localparam logic [3:0] OP_OR   = 4'b1010;
   localparam logic [3:0] OP_NAND = 4'b1011;
   localparam logic [3:0] OP_NOR  = 4'b1100;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // True for the opcodes handled by the iterative datapath.
   function automatic logic is_iter(input logic [3:0] op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/alu_mc_iter.sv
// Iterative one-bit-per-cycle datapath shared by unsigned multiply (shift-add)
// and unsigned divide (restoring). lo/hi present the post-step values.
module alu_mc_iter
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             is_div,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic             done_c,
   output logic [WIDTH-1:0] lo_c,
   output logic [WIDTH-1:0] hi_c
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;

   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] yr;
   logic             div_r;
   logic [CW-1:0]    cnt;

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;
   logic             ge;
   logic [WIDTH-1:0] acc_n;
   logic [WIDTH-1:0] q_n;

   // One step: mul adds the multiplicand and shifts {acc,q} right;
   // div shifts {acc,q} left and keeps the subtraction if it does not borrow.
   always_comb begin
      sum     = {1'b0, acc} + {1'b0, (q[0] ? yr : {WIDTH{1'b0}})};
      shifted = {acc, q[WIDTH-1]};
      ge      = shifted >= {1'b0, yr};
      diff    = shifted - {1'b0, yr};
      if (div_r) begin
         acc_n = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
         q_n   = {q[WIDTH-2:0], ge};
      end else begin
         acc_n = sum[WIDTH:1];
         q_n   = {sum[0], q[WIDTH-1:1]};
      end
   end

   assign done_c = (cnt == CW'(1));
   assign lo_c   = q_n;
   assign hi_c   = acc_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc   <= '0;
         q     <= '0;
         yr    <= '0;
         div_r <= 1'b0;
         cnt   <= '0;
      end else if (start) begin
         acc   <= '0;
         q     <= x;
         yr    <= y;
         div_r <= is_div;
         cnt   <= CW'(WIDTH);
      end else if (cnt != '0) begin
         acc <= acc_n;
         q   <= q_n;
         cnt <= cnt - CW'(1);
      end
   end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: valid/ready request, single-cycle ops registered at accept,
// iterative mul/div, result held in DONE until the consumer takes it.
module alu_mc
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       opselect,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] res,
   output logic             v,
   output logic             zero
);

   state_t state;
   state_t state_nxt;

   logic             is_div_q;
   logic             divz_q;

   logic             start_c;
   logic             wr_c;
   logic [WIDTH-1:0] wr_res_c;
   logic             wr_v_c;

   logic [WIDTH-1:0] sc_res_c;
   logic             sc_v_c;
   logic [WIDTH-1:0] sum_c;
   logic [WIDTH-1:0] dif_c;

   logic             it_done_c;
   logic [WIDTH-1:0] it_lo_c;
   logic [WIDTH-1:0] it_hi_c;

   alu_mc_iter #(.WIDTH(WIDTH)) u_iter (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start_c),
      .is_div (opselect == OP_DIV),
      .x      (x),
      .y      (y),
      .done_c (it_done_c),
      .lo_c   (it_lo_c),
      .hi_c   (it_hi_c)
   );

   // Single-cycle datapath, evaluated on the live operands at the handshake.
   always_comb begin
      sum_c    = x + y;
      dif_c    = x - y;
      sc_res_c = '0;
      sc_v_c   = 1'b0;
      case (opselect)
         OP_ADD: begin
            sc_res_c = sum_c;
            sc_v_c   = (x[WIDTH-1] == y[WIDTH-1]) && (sum_c[WIDTH-1] != x[WIDTH-1]);
         end
         OP_SUB: begin
            sc_res_c = dif_c;
            sc_v_c   = (x[WIDTH-1] != y[WIDTH-1]) && (dif_c[WIDTH-1] != x[WIDTH-1]);
         end
         OP_SHL:  sc_res_c = x << y[SHW-1:0];
         OP_SHR:  sc_res_c = x >> y[SHW-1:0];
         OP_GT:   sc_res_c = {{(WIDTH-1){1'b0}}, ($signed(x) > $signed(y))};
         OP_LT:   sc_res_c = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
         OP_EQ:   sc_res_c = {{(WIDTH-1){1'b0}}, (x == y)};
         OP_AND:  sc_res_c = x & y;
         OP_OR:   sc_res_c = x | y;
         OP_NAND: sc_res_c = ~(x & y);
         OP_NOR:  sc_res_c = ~(x | y);
         default: begin
            sc_res_c = '0;
            sc_v_c   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state and result-write selection.
   always_comb begin
      state_nxt = state;
      start_c   = 1'b0;
      wr_c      = 1'b0;
      wr_res_c  = '0;
      wr_v_c    = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid) begin
               if (is_iter(opselect)) begin
                  start_c   = 1'b1;
                  state_nxt = BUSY;
               end else begin
                  wr_c      = 1'b1;
                  wr_res_c  = sc_res_c;
                  wr_v_c    = sc_v_c;
                  state_nxt = DONE;
               end
            end
         end
         BUSY: begin
            if (it_done_c) begin
               wr_c      = 1'b1;
               wr_res_c  = (is_div_q && divz_q) ? {WIDTH{1'b1}} : it_lo_c;
               wr_v_c    = is_div_q ? divz_q : (it_hi_c != '0);
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res       <= '0;
         v         <= 1'b0;
         zero      <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         is_div_q  <= 1'b0;
         divz_q    <= 1'b0;
      end else begin
         in_ready  <= (state_nxt == IDLE);
         out_valid <= (state_nxt == DONE);
         if (start_c) begin
            is_div_q <= (opselect == OP_DIV);
            divz_q   <= (y == '0);
         end
         if (wr_c) begin
            res  <= wr_res_c;
            v    <= wr_v_c;
            zero <= (wr_res_c == '0);
         end
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc at WIDTH = 32.
module tb_alu_mc;
   import alu_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  opselect;
   logic [31:0] x;
   logic [31:0] y;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] res;
   logic        v;
   logic        zero;

   int checks;
   int failures;

   alu_mc #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .opselect  (opselect),
      .x         (x),
      .y         (y),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .res       (res),
      .v         (v),
      .zero      (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Present a request at the falling edge, accept on the next rising edge,
   // then scramble the inputs to show they were captured.
   task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
      opselect = op;
      x        = a;
      y        = b;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      opselect = 4'hD;
      x        = $urandom;
      y        = $urandom;
   endtask

   task automatic consume();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
      chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
   endtask

   // Count edges until out_valid, bounded; also notes any in_ready while waiting.
   task automatic wait_done(output int n, output int rdy_seen);
      n        = 0;
      rdy_seen = 0;
      while (!out_valid && n < 100) begin
         @(posedge clk);
         #1;
         n++;
         if (in_ready && !out_valid) rdy_seen++;
      end
   endtask

   int n;
   int rdy;
   int spurious;

   initial begin
      checks    = 0;
      failures  = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      opselect  = 4'h0;
      x         = '0;
      y         = '0;

      #12;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_res", res, 32'd0);
      chk("rst_vz", {30'd0, v, zero}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // add overflow, result visible right after the accepting edge
      send(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
      chk("add_out_valid", {31'd0, out_valid}, 32'd1);
      chk("add_res", res, 32'h8000_0000);
      chk("add_v", {31'd0, v}, 32'd1);
      chk("add_zero", {31'd0, zero}, 32'd0);
      consume();

      // multiply overflow: low half zero, 32 edges after accept
      send(OP_MUL, 32'h0001_0000, 32'h0001_0000);
      wait_done(n, rdy);
      chk("mul_latency", 32'(n), 32'd32);
      chk("mul_in_ready_busy", 32'(rdy), 32'd0);
      chk("mul_res", res, 32'h0000_0000);
      chk("mul_v", {31'd0, v}, 32'd1);
      chk("mul_zero", {31'd0, zero}, 32'd1);
      consume();

      send(OP_MUL, 32'd1234, 32'd5678);
      wait_done(n, rdy);
      chk("mul2_res", res, 32'd7006652);
      chk("mul2_v", {31'd0, v}, 32'd0);
      consume();

      send(OP_DIV, 32'd100, 32'd7);
      wait_done(n, rdy);
      chk("div_latency", 32'(n), 32'd32);
      chk("div_res", res, 32'd14);
      chk("div_v", {31'd0, v}, 32'd0);
      consume();

      send(OP_DIV, 32'd5, 32'd0);
      wait_done(n, rdy);
      chk("div0_latency", 32'(n), 32'd32);
      chk("div0_res", res, 32'hFFFF_FFFF);
      chk("div0_v", {31'd0, v}, 32'd1);
      consume();

      // backpressure: result held, new requests ignored
      send(OP_SHL, 32'h0000_0001, 32'd31);
      chk("shl_res", res, 32'h8000_0000);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         opselect = OP_ADD;
         x        = 32'd5;
         y        = 32'd5;
         @(posedge clk);
         #1;
         chk("bp_res", res, 32'h8000_0000);
         chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      end
      in_valid = 1'b0;
      consume();

      send(OP_SHR, 32'h8000_0000, 32'd35);
      chk("shr_res", res, 32'h1000_0000);
      consume();

      send(OP_SUB, 32'h8000_0000, 32'h0000_0001);
      chk("sub_res", res, 32'h7FFF_FFFF);
      chk("sub_v", {31'd0, v}, 32'd1);
      consume();

      send(OP_NAND, 32'hF0F0_FFFF, 32'h0FF0_FFFF);
      chk("nand_res", res, 32'hFF0F_0000);
      consume();

      send(4'b1110, 32'd5, 32'd5);
      chk("rsv_res", res, 32'd0);
      chk("rsv_v", {31'd0, v}, 32'd1);
      chk("rsv_zero", {31'd0, zero}, 32'd1);
      consume();

      send(OP_GT, 32'hFFFF_FFFF, 32'h0000_0001);
      chk("gt_res", res, 32'd0);
      chk("gt_zero", {31'd0, zero}, 32'd1);
      consume();

      send(OP_LT, 32'hFFFF_FFFF, 32'h0000_0001);
      chk("lt_res", res, 32'd1);
      chk("lt_vz", {30'd0, v, zero}, 32'd0);
      consume();

      // reset in the middle of a divide
      send(OP_DIV, 32'd100, 32'd7);
      repeat (9) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_res", res, 32'd0);
      chk("midrst_vz", {30'd0, v, zero}, 32'd0);
      chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      rst_n    = 1'b1;
      spurious = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) spurious++;
      end
      chk("midrst_no_out_valid", 32'(spurious), 32'd0);

      send(OP_ADD, 32'd2, 32'd3);
      chk("recover_res", res, 32'd5);
      consume();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
